// File: rtl/obstacle_streamer.sv
// Streams a frame's obstacle list from BRAM to the projector with a minimum strobe spacing,
// then runs the done/done_ack level handshake. Optional macro: OBSTACLE_SKIP_EMPTY_EN.
module obstacle_streamer #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 2,
    parameter int GAP    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ADDR_W:0]   obstacle_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [15:0]       obstacle,
    output logic              obstacle_valid,
    output logic              done,
    input  logic              done_ack,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    // Handshakes: obstacle_valid is a one-cycle strobe qualifying obstacle (no backpressure);
    // done is a level held until done_ack is seen high, then the block waits for done_ack low.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SPACE   = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_COUNT  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0]      FETCH_LAST = 8'(RD_LAT);
    localparam logic [7:0]      GAP_LAST   = 8'(GAP - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [15:0]         obstacle_q, obstacle_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                advance;
    logic                skip_word;

`ifdef OBSTACLE_SKIP_EMPTY_EN
    assign skip_word = (rd_data == 16'h0000);
`else
    assign skip_word = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        obstacle_d  = obstacle_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        overrun_d   = frame_start && (state_q != S_IDLE);
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    remaining_d = (obstacle_count > MAX_COUNT) ? MAX_COUNT : obstacle_count;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = (obstacle_count != '0) ? S_FETCH : S_HOLD;
                end
            end
            S_FETCH: begin
                // cnt_q == RD_LAT is the cycle in which rd_data reflects rd_addr
                if (cnt_q == FETCH_LAST) begin
                    cnt_d = '0;
                    if (skip_word) begin
                        advance = 1'b1;
                    end else begin
                        obstacle_d = rd_data;
                        valid_d    = 1'b1;
                        state_d    = S_SPACE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SPACE: begin
                if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (done_ack) begin
                    state_d = S_RELEASE;
                end else begin
                    done_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!done_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // idx is left alone on the last word so it never steps past the list end
        if (advance) begin
            cnt_d       = '0;
            remaining_d = remaining_q - (ADDR_W+1)'(1);
            if (remaining_q == (ADDR_W+1)'(1)) begin
                state_d = S_HOLD;
            end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            obstacle_q  <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            obstacle_q  <= obstacle_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_addr        = idx_q;
    assign obstacle       = obstacle_q;
    assign obstacle_valid = valid_q;
    assign done           = done_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_obstacle_streamer.sv
// Directed scoreboard bench for obstacle_streamer: expected words are queued at frame start
// and popped by a negedge monitor on every obstacle_valid strobe.
module tb_obstacle_streamer;

    localparam int ADDR_W = 6;
    localparam int RD_LAT = 2;
    localparam int GAP    = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [ADDR_W:0]   obstacle_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic [15:0]       obstacle;
    logic              obstacle_valid;
    logic              done;
    logic              done_ack;
    logic              busy;
    logic              overrun;
    logic [2:0]        dbg_state;

    obstacle_streamer #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .obstacle_count (obstacle_count),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .obstacle       (obstacle),
        .obstacle_valid (obstacle_valid),
        .done           (done),
        .done_ack       (done_ack),
        .busy           (busy),
        .overrun        (overrun),
        .dbg_state      (dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model with RD_LAT-cycle read pipeline
    logic [15:0] mem [64];
    logic [15:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RD_LAT-1];

    // scoreboard state
    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_q[$];
    int          strobe_cnt      = 0;
    int          ovr_cnt         = 0;
    int          last_strobe_cyc = 0;
    int          start_cyc       = 0;
    int          lat_exp         = 4;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // monitor: pops the expected queue on each strobe, checks spacing and latency
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun) ovr_cnt++;
            if (obstacle_valid) begin
                check("valid_done_exclusive", int'(done), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", int'(obstacle), -1);
                end else begin
                    check("obstacle_word", int'(obstacle), int'(exp_q.pop_front()));
                end
                if (last_strobe_cyc > start_cyc) begin
                    check("strobe_spacing", cyc - last_strobe_cyc, 15);
                end else begin
                    check("first_strobe_latency", cyc - start_cyc, lat_exp);
                end
                last_strobe_cyc = cyc;
                strobe_cnt++;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int cnt);
        tick();
        obstacle_count = (ADDR_W+1)'(cnt);
        frame_start    = 1'b1;
        start_cyc      = cyc;
        tick();
        frame_start    = 1'b0;
    endtask

    task automatic pulse_start(input int cnt);
        tick();
        obstacle_count = (ADDR_W+1)'(cnt);
        frame_start    = 1'b1;
        tick();
        frame_start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic ack_handshake();
        tick();
        done_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("done_low_after_ack", int'(done), 0);
        tick();
        done_ack = 1'b0;
        @(negedge clk);
        check("busy_until_ack_low", int'(busy), 1);
        @(negedge clk);
        check("idle_after_release", int'(busy), 0);
    endtask

    initial begin
        int d;
        int s0;
        int o0;

        rst            = 1'b1;
        frame_start    = 1'b0;
        obstacle_count = '0;
        done_ack       = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        repeat (3) tick();
        @(negedge clk);
        check("reset_valid", int'(obstacle_valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_obstacle", int'(obstacle), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_state", int'(dbg_state), 0);
        tick();
        rst = 1'b0;

        // three words, 15-cycle spacing, done 13 cycles after the last strobe
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
        s0 = strobe_cnt;
        start_frame(3);
        wait_done(200, d);
        check("done_after_last_strobe", d - last_strobe_cyc, 13);
        check("strobe_count_3", strobe_cnt - s0, 3);
        ack_handshake();

        // empty frame: done 2 cycles after the start, ack 5 cycles later
        s0 = strobe_cnt;
        start_frame(0);
        @(negedge clk);
        check("empty_done_early", int'(done), 0);
        check("empty_busy", int'(busy), 1);
        @(negedge clk);
        check("empty_done_rise", int'(done), 1);
        repeat (5) tick();
        done_ack = 1'b1;
        @(negedge clk);
        check("empty_done_held", int'(done), 1);
        @(negedge clk);
        check("empty_done_drop", int'(done), 0);
        check("empty_busy_release", int'(busy), 1);
        tick();
        done_ack = 1'b0;
        @(negedge clk);
        check("empty_busy_ack_low", int'(busy), 1);
        @(negedge clk);
        check("empty_idle", int'(busy), 0);
        check("empty_no_strobes", strobe_cnt - s0, 0);

        // frame_start at the second strobe: overrun once, stream unaffected
        mem[0] = 16'h0AB1; mem[1] = 16'h0AB2; mem[2] = 16'h0AB3;
        exp_q.push_back(16'h0AB1); exp_q.push_back(16'h0AB2); exp_q.push_back(16'h0AB3);
        s0 = strobe_cnt;
        o0 = ovr_cnt;
        start_frame(3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (strobe_cnt - s0 >= 2) break;
        end
        check("second_strobe_seen", strobe_cnt - s0, 2);
        pulse_start(5);
        @(negedge clk);
        check("overrun_pulse", int'(overrun), 1);
        wait_done(200, d);
        check("overrun_done_after_last", d - last_strobe_cyc, 13);
        check("overrun_strobe_count", strobe_cnt - s0, 3);
        check("overrun_once", ovr_cnt - o0, 1);
        ack_handshake();

        // full list, then an oversized count clamped to 64
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 64; i++) exp_q.push_back(16'h1000 + 16'(i));
            s0 = strobe_cnt;
            start_frame(n == 0 ? 64 : 100);
            wait_done(1200, d);
            check("full_strobe_count", strobe_cnt - s0, 64);
            check("full_queue_drained", exp_q.size(), 0);
            ack_handshake();
        end

        // long ack: done drops, block stays busy, frame_start ignored with overrun
        mem[0] = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        s0 = strobe_cnt;
        start_frame(1);
        wait_done(100, d);
        tick();
        done_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("long_ack_done_drop", int'(done), 0);
        pulse_start(3);
        @(negedge clk);
        check("long_ack_overrun", int'(overrun), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("long_ack_busy", int'(busy), 1);
        end
        repeat (5) tick();
        done_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("long_ack_idle", int'(busy), 0);
        repeat (40) @(negedge clk);
        check("long_ack_no_new_frame", int'(busy), 0);
        check("long_ack_strobes", strobe_cnt - s0, 1);

        // reset during HOLD
        start_frame(0);
        wait_done(10, d);
        tick();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_done", int'(done), 0);
        check("rst_hold_busy", int'(busy), 0);
        tick();
        rst = 1'b0;

        // empty-slot frame
        mem[0] = 16'h0000; mem[1] = 16'h00A5; mem[2] = 16'h0000;
        s0 = strobe_cnt;
`ifdef OBSTACLE_SKIP_EMPTY_EN
        exp_q.push_back(16'h00A5);
        lat_exp = 7;
        start_frame(3);
        wait_done(200, d);
        check("skip_strobe_count", strobe_cnt - s0, 1);
`else
        exp_q.push_back(16'h0000); exp_q.push_back(16'h00A5); exp_q.push_back(16'h0000);
        start_frame(3);
        wait_done(200, d);
        check("zero_strobe_count", strobe_cnt - s0, 3);
`endif
        ack_handshake();
        lat_exp = 4;

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/obstacle_streamer.md
Name: obstacle_streamer

Overview:
- Upstream transmitter for the projector's obstacle interface.
- On each frame trigger it reads the frame's obstacle list from an obstacle BRAM and emits one 16-bit obstacle word per `obstacle_valid` pulse, with a minimum spacing so the triangle creator can keep up.
- After the last word it runs the end-of-frame level handshake: `done` is raised and held until the projector acknowledges, then released.
- Sits between the game-state/obstacle memory and the projection pipeline.

Parameters:
- ADDR_W, 6, obstacle BRAM address width; max list length is 2^ADDR_W.
- RD_LAT, 2, BRAM read latency in cycles from `rd_addr` to valid `rd_data`; legal range 1..4.
- GAP, 12, minimum cycles from one `obstacle_valid` pulse to the next; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  single-cycle pulse; begin streaming a frame
- obstacle_count  in  ADDR_W+1  number of obstacles this frame; sampled on the accepted `frame_start`
- rd_addr  out  ADDR_W  obstacle BRAM read address
- rd_data  in  16  BRAM read data, valid RD_LAT cycles after `rd_addr`
- obstacle  out  16  obstacle word to projector
- obstacle_valid  out  1  single-cycle strobe qualifying `obstacle`
- done  out  1  end-of-frame level to projector (`done_in` there)
- done_ack  in  1  projector's `done_out` level
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  one-cycle pulse when `frame_start` arrives while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-frame aborts immediately and drops `done` on the next edge. Any projector resync is the projector reset's responsibility.
- IDLE:
  - On `frame_start`, latch `min(obstacle_count, 2^ADDR_W)` into `remaining`.
  - Clear `idx`.
  - Go to FETCH if `remaining > 0`, else go to HOLD.
- FETCH:
  - Drive `rd_addr = idx`, then wait exactly RD_LAT cycles.
  - On the RD_LAT-th cycle, register `rd_data` into `obstacle` and pulse `obstacle_valid` for one cycle.
  - Go to SPACE.
  - `obstacle` holds its value until the next emit.
- SPACE:
  - Count until GAP cycles have elapsed since the `obstacle_valid` cycle.
  - Then increment `idx` and decrement `remaining`.
  - If `remaining` is now 0, go to HOLD; else go to FETCH.
  - Cycles spent in the next FETCH do not count toward GAP; spacing is at least GAP.
- HOLD:
  - `done = 1`.
  - Stay in HOLD until `done_ack = 1`, then go to RELEASE.
- RELEASE:
  - `done = 0`.
  - Wait until `done_ack = 0`, then go to IDLE.
  - A new frame must never start while `done_ack` is still high.
- `frame_start` in any state other than IDLE:
  - Ignored; pulse `overrun` the same cycle the start is registered.
  - A `frame_start` on the cycle the block returns to IDLE is also ignored. It is only accepted when the state register already reads IDLE.
- `obstacle_count = 2^ADDR_W`: `idx` runs 0..2^ADDR_W-1 with no wrap; `rd_addr` never exceeds 2^ADDR_W-1.
- `done_ack` already high on entry to HOLD (stale ack): it is treated as the ack, giving a HOLD→RELEASE→wait-low sequence.
- `done_ack` is never required to pulse. It is a level and is sampled every cycle in HOLD and RELEASE only.
- `obstacle_valid` and `done` are never high in the same cycle.

Optional Feature:
- Macro: OBSTACLE_SKIP_EMPTY_EN.
- Defined: a fetched word equal to 16'h0000 (empty slot) is not emitted.
  - No `obstacle_valid` and no GAP wait.
  - Go directly to the `idx`/`remaining` update.
  - An all-empty frame goes straight to HOLD with zero strobes.
- Undefined: every fetched word is emitted, including zeros.

Test Plan:
- RD_LAT=2, GAP=12, count=3, BRAM {0x1111, 0x2222, 0x3333}, `frame_start`:
  - Three strobes in order, each exactly 15 cycles apart (GAP + FETCH).
  - `done` rises after the third SPACE.
- count=0:
  - `done` high 2 cycles after `frame_start`, no strobes.
  - Ack high 5 cycles later → `done` low the next cycle.
  - `busy` low one cycle after ack falls.
- Mid-stream `frame_start` at the 2nd strobe:
  - `overrun` pulses once.
  - Stream completes unaffected with exactly `count` strobes.
- count=64 with ADDR_W=6 (also count=100):
  - `rd_addr` covers 0..63 exactly once each.
  - Exactly 64 strobes; `done` then asserted.
- `done_ack` held high 20 cycles after `done` rises:
  - `done` drops after 1 cycle.
  - Block stays busy until ack falls.
  - `frame_start` during the wait → `overrun`, no new frame.
- With OBSTACLE_SKIP_EMPTY_EN, BRAM {0x0000, 0x00A5, 0x0000}, count=3:
  - Exactly one strobe, carrying 0x00A5.
  - Then `done`.
  - `rst` asserted during HOLD → `done` = 0 the next cycle and `busy` = 0.
